// File: rtl/rpc_reg_init_master.sv
// rpc_reg_init_master: boot-time register initialisation sequencer.
// After a start pulse it issues NumWrites register writes over a simple
// valid/ready register bus, then polls a status register until
// (rdata & PollMask) == PollValue or MaxPolls polls have been spent.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   start_i           start pulse (accepted only in IDLE/DONE/FAIL)
//   busy_o            sequence running (WR, GAP, RD)
//   done_o            sequence completed OK (sticky until next start)
//   error_o           sequence failed (sticky until next start)
//   err_idx_o         failing transaction: write index, or NumWrites for poll
//   reg_addr_o ... reg_valid_o   request to the register bus (registered)
//   reg_rdata_i, reg_ready_i, reg_error_i  response from the register bus
module rpc_reg_init_master #(
  parameter int unsigned NumWrites  = 4,
  parameter logic [47:0] BaseAddr   = 48'h0,
  parameter logic [47:0] WrOffset [NumWrites] = '{48'h0, 48'h4, 48'h8, 48'hC},
  parameter logic [31:0] WrData   [NumWrites] = '{default: 32'h0},
  parameter logic [47:0] PollOffset = 48'h10,
  parameter logic [31:0] PollMask   = 32'h1,
  parameter logic [31:0] PollValue  = 32'h1,
  parameter int unsigned PollGap    = 8,
  parameter int unsigned MaxPolls   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [4:0]  err_idx_o,
  output logic [47:0] reg_addr_o,
  output logic        reg_write_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_wstrb_o,
  output logic        reg_valid_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ready_i,
  input  logic        reg_error_i
);

  localparam int unsigned IdxW  = (NumWrites > 1) ? $clog2(NumWrites) : 1;
  localparam int unsigned PollW = $clog2(MaxPolls + 1);
  localparam int unsigned GapW  = (PollGap > 1) ? $clog2(PollGap) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    GAP  = 3'd2,
    RD   = 3'd3,
    DONE = 3'd4,
    FAIL = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic [PollW-1:0]  poll_inc;
  logic [GapW-1:0]   gap_q, gap_d;

  logic        done_d, error_d, busy_d;
  logic [4:0]  err_idx_d;
  logic [47:0] addr_d;
  logic        write_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic        valid_d;

  logic        hs;
  logic        poll_match;

  // Request outputs are registered, so the handshake is seen on the flop copy.
  assign hs         = reg_valid_o && reg_ready_i;
  assign poll_match = ((reg_rdata_i & PollMask) == PollValue);
  assign poll_inc   = poll_q + PollW'(1);

  // State register and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      poll_q      <= '0;
      gap_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      err_idx_o   <= '0;
      reg_addr_o  <= '0;
      reg_write_o <= 1'b0;
      reg_wdata_o <= '0;
      reg_wstrb_o <= '0;
      reg_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      error_o     <= error_d;
      err_idx_o   <= err_idx_d;
      reg_addr_o  <= addr_d;
      reg_write_o <= write_d;
      reg_wdata_o <= wdata_d;
      reg_wstrb_o <= wstrb_d;
      reg_valid_o <= valid_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that the
  // registered bus fields always correspond to the state being entered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    done_d    = done_o;
    error_d   = error_o;
    err_idx_d = err_idx_o;
    busy_d    = 1'b0;
    valid_d   = 1'b0;
    write_d   = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    wstrb_d   = '0;

    unique case (state_q)
      IDLE, DONE, FAIL: begin
        if (start_i) begin
          state_d   = WR;
          idx_d     = '0;
          poll_d    = '0;
          gap_d     = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end

      WR: begin
        if (hs) begin
          if (reg_error_i) begin
            state_d   = FAIL;
            error_d   = 1'b1;
            err_idx_d = 5'(idx_q);
          end else if (idx_q == IdxW'(NumWrites - 1)) begin
            state_d = RD;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      GAP: begin
        if (gap_q == GapW'(PollGap - 1)) begin
          state_d = RD;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      RD: begin
        if (hs) begin
          poll_d = poll_inc;
          // A bus error wins over a matching status value.
          if (reg_error_i) begin
            state_d   = FAIL;
            error_d   = 1'b1;
            err_idx_d = 5'(NumWrites);
          end else if (poll_match) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (poll_inc < PollW'(MaxPolls)) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d   = FAIL;
            error_d   = 1'b1;
            err_idx_d = 5'(NumWrites);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus request for the state being entered; all fields zero when idle.
    unique case (state_d)
      WR: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        write_d = 1'b1;
        addr_d  = BaseAddr + WrOffset[idx_d];
        wdata_d = WrData[idx_d];
        wstrb_d = 4'hF;
      end
      RD: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        addr_d  = BaseAddr + PollOffset;
      end
      GAP: begin
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rpc_reg_init_master.sv
// Bench for rpc_reg_init_master: a bus responder with configurable ready
// pattern, status values and error injection, a scoreboard of expected
// bus requests, and a table of scenarios plus a mid-poll reset sequence.
module tb_rpc_reg_init_master;

  localparam logic [31:0] TbWrData [4] = '{32'hA0A0_0001, 32'hB0B0_0002,
                                           32'hC0C0_0003, 32'hD0D0_0004};
  localparam logic [47:0] TbWrAddr [4] = '{48'h0, 48'h4, 48'h8, 48'hC};

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, error_o;
  logic [4:0]  err_idx_o;
  logic [47:0] reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_valid_o;
  logic [31:0] reg_rdata_i = '0;
  logic        reg_ready_i = 1'b0;
  logic        reg_error_i = 1'b0;

  always #5 clk_i = ~clk_i;

  rpc_reg_init_master #(
    .WrData (TbWrData)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_idx_o   (err_idx_o),
    .reg_addr_o  (reg_addr_o),
    .reg_write_o (reg_write_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wstrb_o (reg_wstrb_o),
    .reg_valid_o (reg_valid_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_ready_i (reg_ready_i),
    .reg_error_i (reg_error_i)
  );

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct {
    int period;      // ready high when cycle % period == 0
    int zero_polls;  // number of leading non-matching status reads
    int err_write;   // write index answered with reg_error_i, -1 for none
    bit poll_err;    // answer the first poll with reg_error_i (and a match)
    bit mid_start;   // pulse start_i while the sequence is busy
    bit exp_done;
    bit exp_error;
    int exp_idx;
    int exp_reads;
  } scen_t;

  scen_t tbl [8];
  txn_t  exp_q [$];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int period = 1, zero_polls = 0, err_write = -1;
  bit poll_err = 1'b0;
  int wr_seen = 0, rd_seen = 0, last_rd = 0;
  bit prev_valid = 1'b0, prev_hs = 1'b0;
  txn_t prev_req;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check the current request and answer it for the coming edge.
  task automatic step();
    txn_t cur;
    txn_t e;
    logic hs;
    @(negedge clk_i);
    cyc++;
    cur = {reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o};
    if (prev_valid && !prev_hs && rst_ni) begin
      chk("hold_valid", 128'(reg_valid_o), 128'(1'b1));
      chk("hold_fields", 128'(cur), 128'(prev_req));
    end
    if (!reg_valid_o) chk("idle_fields", 128'(cur), 128'(0));
    reg_ready_i = ((cyc % period) == 0);
    reg_error_i = 1'b0;
    reg_rdata_i = '0;
    hs = reg_valid_o && reg_ready_i;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 128'(cur), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("req", 128'(cur), 128'(e));
      end
      if (reg_write_o) begin
        if (wr_seen == err_write) reg_error_i = 1'b1;
        wr_seen++;
      end else begin
        rd_seen++;
        if (period == 1 && rd_seen > 1) chk("poll_spacing", 128'(cyc - last_rd), 128'(9));
        last_rd = cyc;
        reg_rdata_i = (rd_seen > zero_polls) ? 32'hFFFF_FFF1 : 32'hFFFF_FFFE;
        if (poll_err) reg_error_i = 1'b1;
      end
    end
    prev_valid = reg_valid_o;
    prev_hs    = hs;
    prev_req   = cur;
  endtask

  task automatic load(input int p, input int zp, input int ew, input bit pe, input int nreads);
    int nwr;
    period = p; zero_polls = zp; err_write = ew; poll_err = pe;
    wr_seen = 0; rd_seen = 0; last_rd = 0;
    exp_q.delete();
    nwr = (ew >= 0) ? ew + 1 : 4;
    for (int w = 0; w < nwr; w++) exp_q.push_back({TbWrAddr[w], 1'b1, TbWrData[w], 4'hF});
    for (int r = 0; r < nreads; r++) exp_q.push_back({48'h10, 1'b0, 32'h0, 4'h0});
  endtask

  task automatic run_scen(input int i);
    scen_t s;
    int n;
    int nwr;
    s = tbl[i];
    load(s.period, s.zero_polls, s.err_write, s.poll_err, s.exp_reads);
    nwr = (s.err_write >= 0) ? s.err_write + 1 : 4;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("busy_after_start", 128'(busy_o), 128'(1'b1));
    chk("done_cleared", 128'(done_o), 128'(1'b0));
    chk("error_cleared", 128'(error_o), 128'(1'b0));
    n = 0;
    while (busy_o && n < 3000) begin
      if (s.mid_start && n == 20) start_i = 1'b1;
      step();
      start_i = 1'b0;
      n++;
    end
    chk($sformatf("s%0d_finished", i), 128'(busy_o), 128'(1'b0));
    chk($sformatf("s%0d_done", i), 128'(done_o), 128'(s.exp_done));
    chk($sformatf("s%0d_error", i), 128'(error_o), 128'(s.exp_error));
    chk($sformatf("s%0d_err_idx", i), 128'(err_idx_o), 128'(s.exp_idx));
    chk($sformatf("s%0d_reads", i), 128'(rd_seen), 128'(s.exp_reads));
    chk($sformatf("s%0d_writes", i), 128'(wr_seen), 128'(nwr));
    chk($sformatf("s%0d_pending", i), 128'(exp_q.size()), 128'(0));
    repeat (3) step();
    chk($sformatf("s%0d_sticky", i), 128'({done_o, error_o, busy_o}),
        128'({s.exp_done, s.exp_error, 1'b0}));
  endtask

  initial begin
    int n;
    //          per zp  ew  pe ms  done err idx reads
    tbl[0] = '{1, 0,  -1, 0, 0, 1,   0,  0,  1};
    tbl[1] = '{3, 0,  -1, 0, 0, 1,   0,  0,  1};
    tbl[2] = '{1, 2,  -1, 0, 1, 1,   0,  0,  3};
    tbl[3] = '{1, 99, -1, 0, 0, 0,   1,  4,  16};
    tbl[4] = '{1, 0,  2,  0, 0, 0,   1,  2,  0};
    tbl[5] = '{2, 1,  -1, 0, 0, 1,   0,  0,  2};
    tbl[6] = '{1, 0,  -1, 1, 0, 0,   1,  4,  1};
    tbl[7] = '{1, 0,  -1, 0, 0, 1,   0,  0,  1};

    repeat (3) @(negedge clk_i);
    chk("reset_outputs", 128'({busy_o, done_o, error_o, err_idx_o, reg_valid_o,
                               reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o}), 128'(0));
    rst_ni = 1'b1;
    load(1, 0, -1, 0, 0);
    step();
    chk("no_req_after_reset", 128'(reg_valid_o), 128'(1'b0));
    step();
    chk("idle_busy", 128'(busy_o), 128'(1'b0));

    for (int i = 0; i < 8; i++) run_scen(i);

    // Reset while a poll request is on the bus.
    load(1, 99, -1, 0, 16);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (!(reg_valid_o && !reg_write_o) && n < 100) begin
      step();
      n++;
    end
    chk("reached_poll", 128'({reg_valid_o, reg_write_o}), 128'(2'b10));
    #2 rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", 128'(reg_valid_o), 128'(1'b0));
    chk("async_reset_all", 128'({busy_o, done_o, error_o, err_idx_o, reg_addr_o,
                                 reg_write_o, reg_wdata_o, reg_wstrb_o}), 128'(0));
    load(1, 0, -1, 0, 0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    chk("post_reset_idle", 128'({reg_valid_o, busy_o}), 128'(0));
    step();
    chk("post_reset_idle2", 128'({reg_valid_o, busy_o}), 128'(0));
    run_scen(0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rpc_reg_init_master.md
RPC_REG_INIT_MASTER -- requirements
Module: rpc_reg_init_master

Interface
REQ-001 SHALL have parameter NumWrites, 4, number of boot-time register writes (1..16).
REQ-002 SHALL have parameter BaseAddr, 48'h0, base address of the RPC controller register file.
REQ-003 SHALL have parameter WrOffset, {48'h0,48'h4,48'h8,48'hC}, per-write address offset array [NumWrites].
REQ-004 SHALL have parameter WrData, all 32'h0, per-write data array [NumWrites]; wstrb is always 4'hF.
REQ-005 SHALL have parameter PollOffset, 48'h10, offset of the ready/status register.
REQ-006 SHALL have parameters PollMask 32'h1 and PollValue 32'h1; poll succeeds when (rdata & PollMask) == PollValue.
REQ-007 SHALL have parameter PollGap, 8, idle cycles between consecutive polls (>=1).
REQ-008 SHALL have parameter MaxPolls, 16, maximum poll reads before timeout (>=1).
REQ-009 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-010 SHALL have ports: start_i in 1 start pulse; busy_o out 1 sequence running; done_o out 1 sequence completed OK (sticky); error_o out 1 sequence failed (sticky); err_idx_o out 5 index of failing transaction (0..NumWrites-1 write, NumWrites = poll).
REQ-011 SHALL have reg bus initiator ports: reg_addr_o out 48; reg_write_o out 1; reg_wdata_o out 32; reg_wstrb_o out 4; reg_valid_o out 1; reg_rdata_i in 32; reg_ready_i in 1; reg_error_i in 1.

Function
REQ-012 SHALL implement states IDLE, WR, GAP, RD, DONE, FAIL.
REQ-013 SHALL move IDLE/DONE/FAIL -> WR on start_i, clearing done_o, error_o, write index, poll counter; start_i in WR/GAP/RD SHALL be ignored.
REQ-014 SHALL, in WR, drive reg_valid_o=1, reg_write_o=1, reg_addr_o=BaseAddr+WrOffset[idx], reg_wdata_o=WrData[idx], reg_wstrb_o=4'hF.
REQ-015 SHALL hold all request fields and reg_valid_o stable until the cycle with reg_valid_o && reg_ready_i (handshake cycle); no timeout on ready.
REQ-016 SHALL, on a WR handshake with reg_error_i=0, increment idx; after idx=NumWrites-1 go to RD with the next cycle issuing the first poll (no gap before first poll).
REQ-017 SHALL, in RD, drive reg_valid_o=1, reg_write_o=0, reg_addr_o=BaseAddr+PollOffset, reg_wdata_o=0, reg_wstrb_o=0.
REQ-018 SHALL sample reg_rdata_i and reg_error_i only in the handshake cycle; poll counter increments on each RD handshake.
REQ-019 SHALL, on RD handshake with match, go to DONE and set done_o the next cycle.
REQ-020 SHALL, on RD handshake without match, go to GAP if poll count < MaxPolls, else FAIL with err_idx_o=NumWrites.
REQ-021 SHALL stay in GAP exactly PollGap cycles with reg_valid_o=0, then return to RD.
REQ-022 SHALL, on any handshake with reg_error_i=1, go to FAIL, set error_o and latch err_idx_o (idx for writes, NumWrites for poll); error takes priority over a poll match.
REQ-023 SHALL drive busy_o=1 exactly in WR, GAP, RD; reg_valid_o=0 in IDLE, GAP, DONE, FAIL.
REQ-024 SHALL drive reg_addr_o/wdata/wstrb/write to 0 when reg_valid_o=0.
REQ-025 SHALL keep done_o and error_o mutually exclusive and sticky until next accepted start_i.
REQ-026 SHALL register all outputs (no combinational path from reg_* inputs to outputs).

Reset
REQ-027 SHALL, on rst_ni low at any time including mid-transaction, asynchronously enter IDLE with all outputs 0, idx=0, poll count=0, gap counter=0.
REQ-028 SHALL not issue any request in the first cycle after reset release unless start_i was seen.

Verification
REQ-029 Default params, reg_ready_i tied 1, status rdata=32'h1: start_i pulse -> 4 writes to 0x0,0x4,0x8,0xC in consecutive cycles, 1 read of 0x10, done_o=1, busy_o=0.
REQ-030 reg_ready_i asserted only every 3rd cycle -> request fields stable while valid and unacked; same address/data order; done_o=1.
REQ-031 Status rdata=0 for 2 polls then 1 -> 3 reads of 0x10 separated by exactly 8 idle cycles; done_o=1.
REQ-032 Status rdata always 0 -> exactly 16 reads, then error_o=1, err_idx_o=4, done_o=0.
REQ-033 reg_error_i=1 on write handshake idx 2 -> no further requests, error_o=1, err_idx_o=2; new start_i restarts from write 0.
REQ-034 rst_ni low during RD with reg_valid_o=1 -> reg_valid_o=0 immediately, busy_o=0, IDLE; start_i after release -> full sequence repeats.
